branch_pc_sequencer: RTL and testbench
======================================

// Module: branch_pc_sequencer
// PURPOSE
//  Owns the program counter and sequences the branch-target adder for the single-clock pipeline.
//  Drives the adder operands, resolves beq/bne/j in ID, selects next PC and flushes IF/ID on redirect.
//  Honours hazard-unit stalls. Keeps saturating perf counters for taken redirects and stall cycles.
//  Sits between the hazard unit, the ID-stage comparator and the IF stage.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC value loaded on reset (must be word-aligned)
//  CNT_W     16             width of each saturating perf counter
// PORTS
//  clk            in   1      system clock, all state on rising edge
//  reset          in   1      synchronous, active-high
//  stall          in   1      hazard unit: hold PC and IF/ID this cycle
//  id_valid       in   1      ID stage holds a real instruction (not a bubble)
//  id_pc_four     in   32     PC+4 of the instruction in ID
//  id_imm         in   16     raw branch immediate from ID
//  id_branch      in   1      ID instruction is beq or bne
//  id_is_bne      in   1      1 = bne, 0 = beq (qualified by id_branch)
//  id_equal       in   1      ID register comparator: rs == rt
//  id_jump        in   1      ID instruction is j
//  id_jtarget     in   26     j instruction index field
//  adder_result   in   32     sum returned by the branch-target adder
//  adder_a        out  32     adder operand A = id_pc_four
//  adder_b        out  32     adder operand B = sign-extended id_imm << 2
//  pc             out  32     current fetch PC (registered)
//  pc_four        out  32     pc + 4, combinational
//  flush_ifid     out  1      IF/ID loads a bubble at the next edge
//  redir_valid    out  1      registered; current fetch is a redirect target
//  taken_cnt      out  CNT_W  count of taken branches + jumps, saturating
//  stall_cnt      out  CNT_W  count of stalled cycles, saturating
// BEHAVIOUR
//  Reset: pc=RESET_PC, redir_valid=0, taken_cnt=0, stall_cnt=0, state=RUN. Reset overrides all.
//  adder_b = {{14{id_imm[15]}}, id_imm, 2'b00}. Mod-2^32 add, no overflow detection.
//  Jump target = {id_pc_four[31:28], id_jtarget, 2'b00}.
//  take_br  = id_valid & id_branch & (id_equal ^ id_is_bne) & ~stall.
//  take_j   = id_valid & id_jump & ~stall.
//  Next-PC priority, registered on the edge (latency 1):
//    reset > stall (hold pc) > take_j > take_br (adder_result) > pc_four.
//  id_jump and id_branch both set: jump wins; taken_cnt increments once.
//  flush_ifid = take_j | take_br (combinational, same cycle as the redirect decision).
//  Never asserted while stall=1. A branch held by stall resolves in the first cycle stall=0.
//  FSM (2-bit state is internal only; it is not a port):
//    RUN   : stall -> STALL; take_j|take_br -> REDIR; else RUN
//    STALL : stall -> STALL; take_j|take_br -> REDIR; else RUN
//    REDIR : one cycle, redir_valid=1. Next state uses the RUN rules (back-to-back redirects allowed).
//  redir_valid = (state == REDIR).
//  stall_cnt increments every cycle stall=1, including stalls entered from REDIR.
//  taken_cnt increments on take_j|take_br.
//  Both counters saturate at all-ones (hold, no wrap).
//  pc wraps mod 2^32; 32'hFFFF_FFFC + 4 = 0.
//  Reset in any state returns to RUN next edge. A pending redirect is discarded.
// STRUCTURE
//  Shared package pipe_pkg:
//    - state localparams ST_RUN=2'd0, ST_STALL=2'd1, ST_REDIR=2'd2
//    - RESET_PC default
//    - sign-extend-shift function used by adder_b
//  One sub-module: sat_counter (CNT_W, inc, reset -> cnt), instantiated twice.
//  The branch-target adder stays external; this block only drives and consumes it.
// TESTING
//  1 Reset held 2 cycles, release, no branches -> pc 0,4,8,C; flush_ifid=0; taken_cnt=0.
//  2 beq, id_pc_four=0x20, id_imm=16'hFFFF, id_equal=1:
//    adder_b=0xFFFFFFFC, flush_ifid=1, next pc=0x1C, redir_valid=1 for one cycle, taken_cnt=1.
//  3 bne with id_equal=1 -> not taken: pc advances by 4, flush_ifid=0, state stays RUN.
//  4 beq taken with stall=1 for 3 cycles: pc held, flush_ifid=0, stall_cnt=3;
//    stall drops -> redirect issued on that cycle.
//  5 id_jump=1 and taken beq together, id_pc_four=0x4000_0010, id_jtarget=26'h10:
//    next pc=0x4000_0040, taken_cnt +1 only.
//  6 CNT_W=2, 5 taken redirects -> taken_cnt=3 (saturated);
//    reset asserted during REDIR -> pc=RESET_PC, counters 0, redir_valid=0 next cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the branch/PC sequencing logic.
//   state_t          : sequencer FSM encoding (2-bit, internal only)
//   RESET_PC_DEFAULT : default fetch address after reset
//   sext_shift2      : branch immediate -> byte offset (sign-extend, << 2)
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_REDIR = 2'd2
    } state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    function automatic logic [31:0] sext_shift2(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-high clear
//   inc   : count this cycle
//   cnt   : current count
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] One = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_q <= cnt_q + One;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/branch_pc_sequencer.sv
// Program-counter owner and branch/jump resolver for the ID stage.
// Ports:
//   clk, reset                 : clock and synchronous active-high reset
//   stall                      : hazard unit hold of PC and IF/ID
//   id_valid .. id_jtarget     : decoded ID-stage branch/jump information
//   adder_result               : sum from the external branch-target adder
//   adder_a, adder_b           : operands driven to that adder
//   pc, pc_four                : registered fetch PC and its +4
//   flush_ifid                 : IF/ID takes a bubble at the next edge
//   redir_valid                : current fetch is a redirect target
//   taken_cnt, stall_cnt       : saturating perf counters
module branch_pc_sequencer
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             id_valid,
    input  logic [31:0]      id_pc_four,
    input  logic [15:0]      id_imm,
    input  logic             id_branch,
    input  logic             id_is_bne,
    input  logic             id_equal,
    input  logic             id_jump,
    input  logic [25:0]      id_jtarget,
    input  logic [31:0]      adder_result,
    output logic [31:0]      adder_a,
    output logic [31:0]      adder_b,
    output logic [31:0]      pc,
    output logic [31:0]      pc_four,
    output logic             flush_ifid,
    output logic             redir_valid,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] jump_target;
    logic        take_br, take_j, redirect;
    state_t      state_q;
    logic        redir_q;

    assign adder_a     = id_pc_four;
    assign adder_b     = sext_shift2(id_imm);
    assign jump_target = {id_pc_four[31:28], id_jtarget, 2'b00};

    // Both decisions are gated by stall so a held branch resolves only once stall drops.
    assign take_br  = id_valid & id_branch & (id_equal ^ id_is_bne) & ~stall;
    assign take_j   = id_valid & id_jump & ~stall;
    assign redirect = take_j | take_br;

    assign flush_ifid = redirect;
    assign pc_four    = pc_q + 32'd4;

    // Jump outranks branch when both are decoded.
    always_comb begin
        pc_d = pc_four;
        if (stall) begin
            pc_d = pc_q;
        end else if (take_j) begin
            pc_d = jump_target;
        end else if (take_br) begin
            pc_d = adder_result;
        end
    end

    // redir_q mirrors (state_q == ST_REDIR) as a registered output.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            state_q <= ST_RUN;
            redir_q <= 1'b0;
        end else begin
            pc_q <= pc_d;
            unique case (state_q)
                // REDIR lasts one cycle and then follows the RUN rules.
                ST_RUN, ST_STALL, ST_REDIR: begin
                    if (stall) begin
                        state_q <= ST_STALL;
                        redir_q <= 1'b0;
                    end else if (redirect) begin
                        state_q <= ST_REDIR;
                        redir_q <= 1'b1;
                    end else begin
                        state_q <= ST_RUN;
                        redir_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_RUN;
                    redir_q <= 1'b0;
                end
            endcase
        end
    end

    assign pc          = pc_q;
    assign redir_valid = redir_q;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_taken_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (redirect),
        .cnt   (taken_cnt)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall),
        .cnt   (stall_cnt)
    );

endmodule

// File: tb/tb_branch_pc_sequencer.sv
module tb_branch_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        id_valid;
    logic [31:0] id_pc_four;
    logic [15:0] id_imm;
    logic        id_branch;
    logic        id_is_bne;
    logic        id_equal;
    logic        id_jump;
    logic [25:0] id_jtarget;
    logic [31:0] adder_result;

    logic [31:0] adder_a, adder_b, pc, pc_four;
    logic        flush_ifid, redir_valid;
    logic [15:0] taken_cnt, stall_cnt;

    logic [31:0] adder_a2, adder_b2, pc2, pc_four2;
    logic        flush_ifid2, redir_valid2;
    logic [1:0]  taken_cnt2, stall_cnt2;

    always #5 clk = ~clk;

    branch_pc_sequencer #(.RESET_PC(32'h0000_0000), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .stall(stall), .id_valid(id_valid),
        .id_pc_four(id_pc_four), .id_imm(id_imm), .id_branch(id_branch),
        .id_is_bne(id_is_bne), .id_equal(id_equal), .id_jump(id_jump),
        .id_jtarget(id_jtarget), .adder_result(adder_result),
        .adder_a(adder_a), .adder_b(adder_b), .pc(pc), .pc_four(pc_four),
        .flush_ifid(flush_ifid), .redir_valid(redir_valid),
        .taken_cnt(taken_cnt), .stall_cnt(stall_cnt)
    );

    // Narrow-counter instance sharing the same stimulus, for saturation.
    branch_pc_sequencer #(.RESET_PC(32'h0000_0000), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .stall(stall), .id_valid(id_valid),
        .id_pc_four(id_pc_four), .id_imm(id_imm), .id_branch(id_branch),
        .id_is_bne(id_is_bne), .id_equal(id_equal), .id_jump(id_jump),
        .id_jtarget(id_jtarget), .adder_result(adder_result),
        .adder_a(adder_a2), .adder_b(adder_b2), .pc(pc2), .pc_four(pc_four2),
        .flush_ifid(flush_ifid2), .redir_valid(redir_valid2),
        .taken_cnt(taken_cnt2), .stall_cnt(stall_cnt2)
    );

    localparam int S_PC = 0, S_PC4 = 1, S_FLUSH = 2, S_REDIR = 3, S_TAKEN = 4, S_STALL = 5;
    localparam int S_AB = 6, S_AA = 7, S_TAKEN2 = 8, S_PC2 = 9, S_STALL2 = 10, S_REDIR2 = 11;
    localparam int S_FLUSH2 = 12, S_AA2 = 13, S_AB2 = 14, S_PC42 = 15;

    typedef struct {
        int          tag;
        int          sel;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    logic [31:0] actual;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] probe(input int sel);
        case (sel)
            S_PC:     return pc;
            S_PC4:    return pc_four;
            S_FLUSH:  return {31'd0, flush_ifid};
            S_REDIR:  return {31'd0, redir_valid};
            S_TAKEN:  return {16'd0, taken_cnt};
            S_STALL:  return {16'd0, stall_cnt};
            S_AB:     return adder_b;
            S_AA:     return adder_a;
            S_TAKEN2: return {30'd0, taken_cnt2};
            S_PC2:    return pc2;
            S_STALL2: return {30'd0, stall_cnt2};
            S_REDIR2: return {31'd0, redir_valid2};
            S_FLUSH2: return {31'd0, flush_ifid2};
            S_AA2:    return adder_a2;
            S_AB2:    return adder_b2;
            S_PC42:   return pc_four2;
            default:  return 32'hxxxx_xxxx;
        endcase
    endfunction

    // Queue an expectation to be checked dly cycles from now.
    task automatic exp_push(input int dly, input int sel, input logic [31:0] val,
                            input string name);
        exp_t e;
        e.tag  = cyc + dly;
        e.sel  = sel;
        e.val  = val;
        e.name = name;
        sb.push_back(e);
    endtask

    // Monitor: compares every expectation due in this cycle, mid-cycle.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].tag == cyc) begin
                actual = probe(sb[i].sel);
                checks++;
                if (actual !== sb[i].val) begin
                    failures++;
                    $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)",
                             sb[i].name, actual, sb[i].val, cyc);
                end
                sb.delete(i);
            end else if (sb[i].tag < cyc) begin
                checks++;
                failures++;
                $display("FAIL %s: not sampled at cycle %0d", sb[i].name, sb[i].tag);
                sb.delete(i);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall = 0; id_valid = 0; id_pc_four = 0; id_imm = 0; id_branch = 0;
        id_is_bne = 0; id_equal = 0; id_jump = 0; id_jtarget = 0; adder_result = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1;
        clear_inputs();
        step();
        step();

        // 1: reset state, then sequential fetch
        exp_push(0, S_PC, 32'h0, "reset_pc");
        exp_push(0, S_REDIR, 32'h0, "reset_redir");
        exp_push(0, S_TAKEN, 32'h0, "reset_taken");
        exp_push(0, S_STALL, 32'h0, "reset_stall");
        reset = 0;
        exp_push(0, S_PC4, 32'h4, "seq_pc_four");
        exp_push(0, S_FLUSH, 32'h0, "seq_flush");
        exp_push(1, S_PC, 32'h4, "seq_pc_4");
        exp_push(2, S_PC, 32'h8, "seq_pc_8");
        exp_push(3, S_PC, 32'hC, "seq_pc_c");
        exp_push(3, S_TAKEN, 32'h0, "seq_taken");
        step(); step(); step();

        // 2: taken beq with negative offset
        id_valid = 1; id_branch = 1; id_is_bne = 0; id_equal = 1;
        id_pc_four = 32'h20; id_imm = 16'hFFFF; adder_result = 32'h1C;
        exp_push(0, S_AA, 32'h20, "beq_adder_a");
        exp_push(0, S_AB, 32'hFFFF_FFFC, "beq_adder_b");
        exp_push(0, S_FLUSH, 32'h1, "beq_flush");
        exp_push(0, S_REDIR, 32'h0, "beq_redir_before");
        exp_push(1, S_PC, 32'h1C, "beq_pc");
        exp_push(1, S_REDIR, 32'h1, "beq_redir");
        exp_push(1, S_TAKEN, 32'h1, "beq_taken");
        exp_push(0, S_FLUSH2, 32'h1, "beq_flush_n2");
        exp_push(0, S_AA2, 32'h20, "beq_adder_a_n2");
        exp_push(0, S_AB2, 32'hFFFF_FFFC, "beq_adder_b_n2");
        exp_push(1, S_REDIR2, 32'h1, "beq_redir_n2");
        exp_push(1, S_TAKEN2, 32'h1, "beq_taken_n2");
        exp_push(1, S_PC42, 32'h20, "beq_pc_four_n2");
        step();
        clear_inputs();
        exp_push(0, S_FLUSH, 32'h0, "post_beq_flush");
        exp_push(1, S_REDIR, 32'h0, "redir_one_cycle");
        exp_push(1, S_PC, 32'h20, "post_beq_pc");
        step();

        // 3: bne with equal operands is not taken
        id_valid = 1; id_branch = 1; id_is_bne = 1; id_equal = 1;
        id_pc_four = 32'h24; id_imm = 16'h0040; adder_result = 32'hDEAD_0000;
        exp_push(0, S_FLUSH, 32'h0, "bne_nt_flush");
        exp_push(1, S_PC, 32'h24, "bne_nt_pc");
        exp_push(1, S_REDIR, 32'h0, "bne_nt_redir");
        exp_push(1, S_TAKEN, 32'h1, "bne_nt_taken");
        step();

        // 4: taken beq held by a 3-cycle stall
        id_valid = 1; id_branch = 1; id_is_bne = 0; id_equal = 1;
        id_pc_four = 32'h100; id_imm = 16'h0010; adder_result = 32'h140;
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            exp_push(0, S_FLUSH, 32'h0, "stall_flush");
            exp_push(0, S_PC, 32'h24, "stall_pc_hold");
            exp_push(0, S_STALL, i, "stall_cnt_run");
            exp_push(0, S_REDIR, 32'h0, "stall_redir");
            step();
        end
        stall = 0;
        exp_push(0, S_STALL, 32'h3, "stall_cnt_3");
        exp_push(0, S_PC, 32'h24, "stall_pc_held");
        exp_push(0, S_FLUSH, 32'h1, "unstall_flush");
        exp_push(1, S_PC, 32'h140, "unstall_pc");
        exp_push(1, S_REDIR, 32'h1, "unstall_redir");
        exp_push(1, S_TAKEN, 32'h2, "unstall_taken");
        exp_push(1, S_STALL, 32'h3, "unstall_stall_cnt");
        exp_push(1, S_STALL2, 32'h3, "stall_cnt_n2");
        step();

        // 5: jump and taken beq together, back-to-back with previous redirect
        clear_inputs();
        id_valid = 1; id_jump = 1; id_branch = 1; id_is_bne = 0; id_equal = 1;
        id_pc_four = 32'h4000_0010; id_jtarget = 26'h10; adder_result = 32'h1234_5678;
        exp_push(0, S_REDIR, 32'h1, "jb_redir_prev");
        exp_push(0, S_FLUSH, 32'h1, "jb_flush");
        exp_push(1, S_PC, 32'h4000_0040, "jb_pc");
        exp_push(1, S_TAKEN, 32'h3, "jb_taken");
        exp_push(1, S_REDIR, 32'h1, "jb_redir");
        exp_push(1, S_TAKEN2, 32'h3, "jb_taken_n2");
        step();
        clear_inputs();
        exp_push(0, S_PC4, 32'h4000_0044, "jb_pc_four");
        exp_push(1, S_PC, 32'h4000_0044, "jb_seq_pc");
        exp_push(1, S_REDIR, 32'h0, "jb_redir_drop");
        step();

        // PC wrap: jump to the last word, then pc_four wraps to 0
        id_valid = 1; id_jump = 1; id_pc_four = 32'hF000_0000; id_jtarget = 26'h3FF_FFFF;
        exp_push(1, S_PC, 32'hFFFF_FFFC, "wrap_pc");
        exp_push(1, S_PC4, 32'h0, "wrap_pc_four");
        exp_push(1, S_TAKEN, 32'h4, "wrap_taken");
        exp_push(1, S_TAKEN2, 32'h3, "wrap_taken_n2");
        step();

        // 6: fifth redirect saturates the narrow counter, then reset in REDIR
        id_pc_four = 32'h0; id_jtarget = 26'h100;
        exp_push(1, S_PC, 32'h400, "j5_pc");
        exp_push(1, S_TAKEN, 32'h5, "j5_taken");
        exp_push(1, S_TAKEN2, 32'h3, "j5_taken_sat");
        step();
        reset = 1;
        exp_push(0, S_REDIR, 32'h1, "rst_in_redir");
        exp_push(1, S_PC, 32'h0, "rst_pc");
        exp_push(1, S_REDIR, 32'h0, "rst_redir");
        exp_push(1, S_TAKEN, 32'h0, "rst_taken");
        exp_push(1, S_STALL, 32'h0, "rst_stall");
        exp_push(1, S_TAKEN2, 32'h0, "rst_taken_n2");
        exp_push(1, S_STALL2, 32'h0, "rst_stall_n2");
        exp_push(1, S_PC2, 32'h0, "rst_pc_n2");
        step();
        reset = 0;
        clear_inputs();
        exp_push(1, S_PC, 32'h4, "post_rst_pc");
        exp_push(1, S_REDIR, 32'h0, "post_rst_redir");
        step();

        step(); step(); step();
        for (int i = 0; i < sb.size(); i++) begin
            checks++;
            failures++;
            $display("FAIL %s: expectation still pending", sb[i].name);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
